// File: rtl/udp_rx_frame_parser.sv
// Parses SYNC/LEN/payload/CHK frames from the UDP receive byte stream into a commit/rollback FIFO.
// Optional feature macro: RX_TIMEOUT_EN (abort a frame after TIMEOUT_CYC cycles without a byte).
module udp_rx_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'h55,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned FIFO_AW     = 7,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxdat_vld,
  input  logic [7:0]         rxdat,
  input  logic               rxdat_end,
  output logic [7:0]         o_dat,
  output logic               o_dat_vld,
  input  logic               dat_rdy,
  output logic               o_frm_ok,
  output logic               o_frm_err,
  output logic [15:0]        o_err_cnt,
  output logic [FIFO_AW:0]   o_fifo_cnt
);

  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic            frm_ok_q, frm_ok_d;
  logic            frm_err_q, frm_err_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [7:0]      mem_q [DEPTH];
  logic            wr_en;
  logic            err;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            tmo_hit;

  // Full counts speculative bytes too; empty only looks at committed data.
  assign fifo_full  = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign fifo_empty = (rd_ptr_q == cmt_ptr_q);
  assign pop        = !fifo_empty && dat_rdy;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Idle-cycle counter, live only while a datagram is in progress.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (!rxdat_vld && state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) tmo_hit = 1'b1;
      else                               tmo_d   = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      frm_ok_q  <= 1'b0;
      frm_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      frm_ok_q  <= frm_ok_d;
      frm_err_q <= frm_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= rxdat;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    frm_ok_d  = 1'b0;
    err       = 1'b0;
    wr_en     = 1'b0;

    if (rxdat_vld) begin
      case (state_q)
        S_IDLE: begin
          if (rxdat == SYNC_BYTE && !rxdat_end) state_d = S_LEN;
          else                                  err     = 1'b1;
        end
        S_LEN: begin
          if (rxdat_end || rxdat == 8'd0 || rxdat > 8'(MAX_LEN)) begin
            err = 1'b1;
          end else begin
            cnt_d   = rxdat;
            sum_d   = rxdat;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (fifo_full || rxdat_end) begin
            err = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            sum_d    = sum_q + rxdat;
            cnt_d    = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_CHK;
          end
        end
        S_CHK: begin
          if (rxdat == sum_q && rxdat_end) begin
            cmt_ptr_d = wr_ptr_q;
            frm_ok_d  = 1'b1;
            state_d   = S_IDLE;
          end else begin
            err = 1'b1;
          end
        end
        S_DROP: begin
          if (rxdat_end) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (err) begin
        wr_ptr_d = cmt_ptr_q;
        state_d  = rxdat_end ? S_IDLE : S_DROP;
      end
    end else if (tmo_hit) begin
      // A stalled DROP already reported its error; just return to IDLE.
      err      = (state_q != S_DROP);
      wr_ptr_d = cmt_ptr_q;
      state_d  = S_IDLE;
    end

    frm_err_d = err;
    err_cnt_d = (err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  assign o_dat      = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign o_dat_vld  = !fifo_empty;
  assign o_fifo_cnt = cmt_ptr_q - rd_ptr_q;
  assign o_frm_ok   = frm_ok_q;
  assign o_frm_err  = frm_err_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_udp_rx_frame_parser.sv
// Directed bench for udp_rx_frame_parser: frame-position model plus literal spot checks.
module tb_udp_rx_frame_parser;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXL  = 8;
  localparam int unsigned TMO   = 100;
  localparam logic [7:0]  SYNC  = 8'h55;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxdat_vld = 1'b0;
  logic [7:0]  rxdat = 8'h00;
  logic        rxdat_end = 1'b0;
  logic [7:0]  o_dat;
  logic        o_dat_vld;
  logic        dat_rdy = 1'b0;
  logic        o_frm_ok;
  logic        o_frm_err;
  logic [15:0] o_err_cnt;
  logic [AW:0] o_fifo_cnt;

  udp_rx_frame_parser #(
    .SYNC_BYTE  (SYNC),
    .MAX_LEN    (MAXL),
    .FIFO_AW    (AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxdat_vld (rxdat_vld),
    .rxdat     (rxdat),
    .rxdat_end (rxdat_end),
    .o_dat     (o_dat),
    .o_dat_vld (o_dat_vld),
    .dat_rdy   (dat_rdy),
    .o_frm_ok  (o_frm_ok),
    .o_frm_err (o_frm_err),
    .o_err_cnt (o_err_cnt),
    .o_fifo_cnt(o_fifo_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_ok = 0;
  int n_err = 0;
  logic [7:0] got[$];
  logic [7:0] fr[$];

  // Model: committed queue, speculative queue and position within the datagram.
  logic [7:0] mq[$];
  logic [7:0] pend[$];
  int         pos = 0;
  int         len = 0;
  bit         dead = 1'b0;
  logic [7:0] sum = 8'h00;
  int         m_errcnt = 0;
  bit         m_ok = 1'b0;
  bit         m_err = 1'b0;
  int         tmo = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    pos = 0; len = 0; dead = 1'b0; sum = 8'h00;
    m_errcnt = 0; m_ok = 1'b0; m_err = 1'b0; tmo = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic e, input logic r);
    bit full;
    bit fail;
    full  = (mq.size() + pend.size()) >= DEPTH;
    m_ok  = 1'b0;
    m_err = 1'b0;
    fail  = 1'b0;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v) begin
      tmo = 0;
      if (dead) begin
        if (e) dead = 1'b0;
      end else if (pos == 0) begin
        if (b == SYNC && !e) pos = 1; else fail = 1'b1;
      end else if (pos == 1) begin
        if (e || b == 8'd0 || int'(b) > int'(MAXL)) fail = 1'b1;
        else begin len = int'(b); sum = b; pos = 2; end
      end else if (pos < len + 2) begin
        if (full || e) fail = 1'b1;
        else begin pend.push_back(b); sum = sum + b; pos++; end
      end else begin
        if (b == sum && e) begin
          foreach (pend[i]) mq.push_back(pend[i]);
          pend.delete();
          m_ok = 1'b1;
          pos = 0;
        end else fail = 1'b1;
      end
      if (fail) begin pend.delete(); pos = 0; dead = !e; end
    end
`ifdef RX_TIMEOUT_EN
    else if (pos != 0 || dead) begin
      tmo++;
      if (tmo == int'(TMO)) begin
        tmo = 0;
        if (!dead) fail = 1'b1;
        pend.delete(); pos = 0; dead = 1'b0;
      end
    end
`endif
    if (fail) begin
      m_err = 1'b1;
      if (m_errcnt < 32'hFFFF) m_errcnt++;
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
  always @(negedge clk) begin
    chk("frm_ok",   32'(o_frm_ok),   32'(m_ok));
    chk("frm_err",  32'(o_frm_err),  32'(m_err));
    chk("err_cnt",  32'(o_err_cnt),  32'(m_errcnt));
    chk("dat_vld",  32'(o_dat_vld),  32'(mq.size() > 0));
    chk("fifo_cnt", 32'(o_fifo_cnt), 32'(mq.size()));
    chk("dat",      32'(o_dat),      (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    if (o_frm_ok) n_ok++;
    if (o_frm_err) n_err++;
    if (o_dat_vld === 1'b1 && dat_rdy) got.push_back(o_dat);
    if (!rst_n) model_reset();
    else        model_step(rxdat_vld, rxdat, rxdat_end, dat_rdy);
  end

  task automatic send(input bit with_end);
    foreach (fr[i]) begin
      @(posedge clk); #1;
      rxdat_vld = 1'b1;
      rxdat     = fr[i];
      rxdat_end = with_end && (i == fr.size() - 1);
    end
    @(posedge clk); #1;
    rxdat_vld = 1'b0;
    rxdat_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    chk("rst_err_cnt",  32'(o_err_cnt),  32'd0);
    chk("rst_fifo_cnt", 32'(o_fifo_cnt), 32'd0);
    chk("rst_dat_vld",  32'(o_dat_vld),  32'd0);
    chk("rst_dat",      32'(o_dat),      32'd0);
    rst_n = 1'b1;
    idle(2);

    dat_rdy = 1'b1;
    fr = {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send(1'b1); idle(4);
    chk("good_ok",    32'(n_ok), 32'd1);
    chk("good_npop",  32'(got.size()), 32'd3);
    chk("good_b0",    32'(got[0]), 32'h11);
    chk("good_b1",    32'(got[1]), 32'h22);
    chk("good_b2",    32'(got[2]), 32'h33);
    chk("good_err",   32'(o_err_cnt), 32'd0);

    fr = {8'h55, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send(1'b1); idle(3);
    chk("badchk_err", 32'(o_err_cnt), 32'd1);
    chk("badchk_pls", 32'(n_err), 32'd1);
    chk("badchk_vld", 32'(o_dat_vld), 32'd0);

    fr = {8'h55, 8'h04, 8'h01, 8'h02};
    send(1'b1);
    fr = {8'h55, 8'h01, 8'h7E, 8'h7F};
    send(1'b1); idle(4);
    chk("early_err",  32'(o_err_cnt), 32'd2);
    chk("early_ok",   32'(n_ok), 32'd2);
    chk("early_npop", 32'(got.size()), 32'd4);
    chk("early_b",    32'(got[3]), 32'h7E);

    fr = {8'h55, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(1'b1);
    fr = {8'h55, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(1'b1); idle(3);
    chk("len_err",    32'(o_err_cnt), 32'd4);
    chk("len_pls",    32'(n_err), 32'd4);

    fr = {8'h55};
    send(1'b1);
    fr = {8'h55, 8'h01, 8'h05, 8'h06, 8'h07};
    send(1'b1); idle(3);
    chk("noend_err",  32'(o_err_cnt), 32'd6);
    chk("noend_ok",   32'(n_ok), 32'd2);

    dat_rdy = 1'b0;
    fr = {8'h55, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1B};
    send(1'b1); idle(3);
    chk("fillA_cnt",  32'(o_fifo_cnt), 32'd6);
    chk("fillA_ok",   32'(n_ok), 32'd3);
    fr = {8'h55, 8'h06, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h75};
    send(1'b1); idle(3);
    chk("ovf_cnt",    32'(o_fifo_cnt), 32'd6);
    chk("ovf_err",    32'(o_err_cnt), 32'd7);
    dat_rdy = 1'b1;
    send(1'b1); idle(10);
    chk("drain_ok",   32'(n_ok), 32'd4);
    chk("drain_npop", 32'(got.size()), 32'd16);
    chk("drain_b4",   32'(got[4]), 32'h01);
    chk("drain_b9",   32'(got[9]), 32'h06);
    chk("drain_b10",  32'(got[10]), 32'h10);
    chk("drain_b15",  32'(got[15]), 32'h15);
    chk("drain_cnt",  32'(o_fifo_cnt), 32'd0);

    fr = {8'h55, 8'h03, 8'h11};
    send(1'b0); idle(105);
    fr = {8'h22, 8'h33, 8'h69};
    send(1'b1); idle(4);
`ifdef RX_TIMEOUT_EN
    chk("tmo_err",    32'(o_err_cnt), 32'd9);
    chk("tmo_ok",     32'(n_ok), 32'd4);
`else
    chk("tmo_err",    32'(o_err_cnt), 32'd7);
    chk("tmo_ok",     32'(n_ok), 32'd5);
    chk("tmo_npop",   32'(got.size()), 32'd19);
    chk("tmo_b",      32'(got[18]), 32'h33);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
